// File: rtl/timer_display.sv
// Display back end for the countdown/stopwatch timer: clamps the binary time, converts it to BCD
// with a sequential double-dabble engine and scans an 8-digit common-anode seven-segment display.
module timer_display #(
  parameter int SCAN_CYCLES  = 100_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  minute,
  input  logic [7:0]  second,
  input  logic [11:0] micro_second,
  input  logic        finish,
  input  logic        set,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int SCAN_W  = (SCAN_CYCLES  > 1) ? $clog2(SCAN_CYCLES)  : 1;
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Two BCD digits suffice for minutes/seconds: the clamped value never exceeds 99.
  function automatic logic [7:0] dabble2(input logic [7:0] b, input logic in_bit);
    logic [7:0] a;
    a = {add3(b[7:4]), add3(b[3:0])};
    return {a[6:0], in_bit};
  endfunction

  function automatic logic [11:0] dabble3(input logic [11:0] b, input logic in_bit);
    logic [11:0] a;
    a = {add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
    return {a[10:0], in_bit};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_OFF;
    endcase
  endfunction

  logic [7:0]  min_cl, sec_cl;
  logic [11:0] ms_cl;

  assign min_cl = (minute > 8'd99) ? 8'd99 : minute;
  assign sec_cl = (second > 8'd99) ? 8'd99 : second;
  assign ms_cl  = (micro_second > 12'd999) ? 12'd999 : micro_second;

  logic [1:0]  state_q, state_d;
  logic [3:0]  iter_q, iter_d;
  logic [11:0] bin_min_q, bin_min_d, bin_sec_q, bin_sec_d, bin_ms_q, bin_ms_d;
  logic [7:0]  bcd_min_q, bcd_min_d, bcd_sec_q, bcd_sec_d;
  logic [11:0] bcd_ms_q, bcd_ms_d;
  logic [27:0] disp_q, disp_d;

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    bin_min_d = bin_min_q;
    bin_sec_d = bin_sec_q;
    bin_ms_d  = bin_ms_q;
    bcd_min_d = bcd_min_q;
    bcd_sec_d = bcd_sec_q;
    bcd_ms_d  = bcd_ms_q;
    disp_d    = disp_q;
    case (state_q)
      ST_IDLE: begin
        bin_min_d = {4'd0, min_cl};
        bin_sec_d = {4'd0, sec_cl};
        bin_ms_d  = ms_cl;
        bcd_min_d = '0;
        bcd_sec_d = '0;
        bcd_ms_d  = '0;
        iter_d    = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        bcd_min_d = dabble2(bcd_min_q, bin_min_q[11]);
        bcd_sec_d = dabble2(bcd_sec_q, bin_sec_q[11]);
        bcd_ms_d  = dabble3(bcd_ms_q, bin_ms_q[11]);
        bin_min_d = {bin_min_q[10:0], 1'b0};
        bin_sec_d = {bin_sec_q[10:0], 1'b0};
        bin_ms_d  = {bin_ms_q[10:0], 1'b0};
        iter_d    = iter_q + 4'd1;
        if (iter_q == 4'd11) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        // All seven digits land together so the scan never shows a half-updated frame.
        disp_d  = {bcd_min_q, bcd_sec_q, bcd_ms_q};
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      disp_q  <= disp_d;
    end
  end

  always_ff @(posedge clk) begin
    bin_min_q <= bin_min_d;
    bin_sec_q <= bin_sec_d;
    bin_ms_q  <= bin_ms_d;
    bcd_min_q <= bcd_min_d;
    bcd_sec_q <= bcd_sec_d;
    bcd_ms_q  <= bcd_ms_d;
  end

  logic [SCAN_W-1:0] scan_cnt_q;
  logic [2:0]        idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= 3'd7;
    end else if (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1)) begin
      scan_cnt_q <= '0;
      idx_q      <= idx_q - 3'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
    end
  end

  logic               done_q, done_d, off_q, off_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

  always_comb begin
    done_d      = done_q;
    off_d       = off_q;
    blink_cnt_d = blink_cnt_q;
    if (set) begin
      done_d      = 1'b0;
      off_d       = 1'b0;
      blink_cnt_d = '0;
    end else if (!done_q) begin
      // A fresh finish always starts on the lit half-period.
      done_d      = finish;
      off_d       = 1'b0;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt_d = '0;
      off_d       = ~off_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q      <= 1'b0;
      off_q       <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      done_q      <= done_d;
      off_q       <= off_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  logic [3:0] nib;
  logic       dash;
  logic [7:0] an_d, an_q;
  logic [6:0] seg_d, seg_q;
  logic       dp_d, dp_q;

  always_comb begin
    nib  = 4'd0;
    dash = 1'b0;
    case (idx_q)
      3'd7:    nib = disp_q[27:24];
      3'd6:    nib = disp_q[23:20];
      3'd5:    nib = disp_q[19:16];
      3'd4:    nib = disp_q[15:12];
      3'd3:    dash = 1'b1;
      3'd2:    nib = disp_q[11:8];
      3'd1:    nib = disp_q[7:4];
      default: nib = disp_q[3:0];
    endcase
    seg_d = dash ? SEG_DASH : seg7(nib);
    dp_d  = !((idx_q == 3'd6) || (idx_q == 3'd4));
    an_d  = (done_q && off_q) ? 8'hFF : ~(8'd1 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: doc/timer_display.md
# timer_display

Display back end for the countdown/stopwatch timer. Takes the timer's binary minute/second/millisecond values and its finish pulse, converts them to BCD with a sequential double-dabble engine, and drives an 8-digit common-anode seven-segment display by time multiplexing. It sits between the timer and the board pins and is the only consumer of the timer's value outputs.

## Interface
- SCAN_CYCLES, 100_000: clk cycles each digit stays lit (1 ms at 100 MHz); must be ≥ 16.
- BLINK_CYCLES, 25_000_000: clk cycles per on/off half-period while blinking.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- minute  in  8  binary minutes from the timer.
- second  in  8  binary seconds from the timer.
- micro_second  in  12  binary milliseconds from the timer.
- finish  in  1  one-cycle pulse from the timer when the count completes.
- set  in  1  timer reload; also clears the blink flag.
- an  out  8  digit enables, active-low, one-hot (bit 7 is the leftmost digit).
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Digit map: 7-6 show minute tens/units; 5-4 show second tens/units; 3 shows '-' (seg = 7'b0111111); 2-0 show ms hundreds/tens/units.
- dp is lit on digit 6 and digit 4 only.
- Clamp before conversion: minute > 99 becomes 99; second > 99 becomes 99; micro_second > 999 becomes 999.
- Converter FSM states:
  - IDLE: captures the clamped inputs into a snapshot and goes to SHIFT.
  - SHIFT: 12 iterations. Each iteration first adds 3 to every BCD nibble ≥ 5, then shifts left by 1. All three fields are converted in parallel; minute/second are zero-extended to 12 bits.
  - COMMIT: copies all 7 BCD digits into the display register in one cycle, then returns to IDLE.
  - Conversion runs continuously. Because the display register is written atomically in COMMIT, a mixed old/new frame never appears.
- Scan:
  - scan_cnt counts 0..SCAN_CYCLES-1.
  - On wrap, digit index advances 7→6→…→0→7.
  - an is low only for the current index.
- Segment decode: hex digits 0-9 use the standard patterns. Any BCD nibble > 9 is impossible by construction; the decoder outputs all-off for it.
- Blink:
  - The finish pulse sets done.
  - set or rst clears done. If set and finish are high in the same cycle, set wins.
  - While done, blink_cnt runs. During the off half-period, an = 8'hFF.
  - blink_cnt restarts at 0 when done rises, and that half-period is on.
  - While done is 0, blink_cnt holds at 0.

## Timing
- Reset values: an = 8'hFF, seg = 7'h7F, dp = 1, digit index = 7, scan_cnt = 0, display register = all zero digits, FSM = IDLE, done = 0, blink_cnt = 0.
- Cycle 1 after rst deasserts:
  - an = 8'h7F, showing digit 7 = '0' from the zeroed display register.
  - All outputs are registered, one cycle behind the index/display register.
- Conversion latency: 14 cycles from snapshot to display register (1 IDLE + 12 SHIFT + 1 COMMIT). A new snapshot is taken every 14 cycles.
- An input change is visible in the display register at most 28 cycles later.
- Digit period is exactly SCAN_CYCLES; full frame is 8×SCAN_CYCLES.
- rst mid-conversion: the partial result is discarded and the display register returns to zeros.
- A finish pulse arriving while done is already set has no effect; the blink phase is not restarted.

## Test plan
- Reset/first frame (SCAN_CYCLES=16): hold rst 3 cycles, release with inputs 0 → an=8'hFF during reset. One cycle later an=8'h7F, seg=7'b1000000, dp=1. Digits 6 and 4 have dp=0; digit 3 seg=7'b0111111.
- Conversion: minute=12, second=34, micro_second=567 → within 28 cycles digits 7..0 show 1,2,3,4,-,5,6,7. Sample each digit's seg on its scan slot.
- Clamp: minute=200, second=255, micro_second=4095 → display shows 99, 99, 999.
- No tearing: change inputs from 59:59.999 to 00:00.000 on every cycle for 200 cycles. At every COMMIT, the display register must equal exactly one of the two snapshots.
- Blink (BLINK_CYCLES=32): pulse finish → an toggles between scanning and 8'hFF every 32 cycles, starting with on. A second finish pulse leaves the phase unchanged. set → scanning resumes without gaps. set and finish in the same cycle → done stays 0.
- Reset mid-operation: assert rst during SHIFT and again while blinking → all outputs return to their reset values on the next cycle. The display resumes from zeros after release.
